// File: rtl/aes_pkg.sv
// Shared AES-128 constants, the key-expander state type and small word helpers.
package aes_pkg;

    localparam int AES_KEY_W  = 128;
    localparam int AES_WORD_W = 32;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        EMIT = 1'b1
    } state_e;

    localparam logic [7:0] RCON [0:9] = '{
        8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
    };

    function automatic logic [AES_WORD_W-1:0] rotword(input logic [AES_WORD_W-1:0] w);
        return {w[AES_WORD_W-9:0], w[AES_WORD_W-1:AES_WORD_W-8]};
    endfunction

endpackage

// File: rtl/aes_sbox.sv
// Combinational AES forward S-box, one byte per instance; reused by SubWord and SubBytes.
module aes_sbox (
    input  logic [7:0] i_byte,
    output logic [7:0] o_byte
);

    always_comb begin
        o_byte = 8'h00;
        case (i_byte)
            8'h00: o_byte = 8'h63; 8'h01: o_byte = 8'h7c; 8'h02: o_byte = 8'h77; 8'h03: o_byte = 8'h7b; 8'h04: o_byte = 8'hf2; 8'h05: o_byte = 8'h6b; 8'h06: o_byte = 8'h6f; 8'h07: o_byte = 8'hc5; 8'h08: o_byte = 8'h30; 8'h09: o_byte = 8'h01; 8'h0a: o_byte = 8'h67; 8'h0b: o_byte = 8'h2b; 8'h0c: o_byte = 8'hfe; 8'h0d: o_byte = 8'hd7; 8'h0e: o_byte = 8'hab; 8'h0f: o_byte = 8'h76;
            8'h10: o_byte = 8'hca; 8'h11: o_byte = 8'h82; 8'h12: o_byte = 8'hc9; 8'h13: o_byte = 8'h7d; 8'h14: o_byte = 8'hfa; 8'h15: o_byte = 8'h59; 8'h16: o_byte = 8'h47; 8'h17: o_byte = 8'hf0; 8'h18: o_byte = 8'had; 8'h19: o_byte = 8'hd4; 8'h1a: o_byte = 8'ha2; 8'h1b: o_byte = 8'haf; 8'h1c: o_byte = 8'h9c; 8'h1d: o_byte = 8'ha4; 8'h1e: o_byte = 8'h72; 8'h1f: o_byte = 8'hc0;
            8'h20: o_byte = 8'hb7; 8'h21: o_byte = 8'hfd; 8'h22: o_byte = 8'h93; 8'h23: o_byte = 8'h26; 8'h24: o_byte = 8'h36; 8'h25: o_byte = 8'h3f; 8'h26: o_byte = 8'hf7; 8'h27: o_byte = 8'hcc; 8'h28: o_byte = 8'h34; 8'h29: o_byte = 8'ha5; 8'h2a: o_byte = 8'he5; 8'h2b: o_byte = 8'hf1; 8'h2c: o_byte = 8'h71; 8'h2d: o_byte = 8'hd8; 8'h2e: o_byte = 8'h31; 8'h2f: o_byte = 8'h15;
            8'h30: o_byte = 8'h04; 8'h31: o_byte = 8'hc7; 8'h32: o_byte = 8'h23; 8'h33: o_byte = 8'hc3; 8'h34: o_byte = 8'h18; 8'h35: o_byte = 8'h96; 8'h36: o_byte = 8'h05; 8'h37: o_byte = 8'h9a; 8'h38: o_byte = 8'h07; 8'h39: o_byte = 8'h12; 8'h3a: o_byte = 8'h80; 8'h3b: o_byte = 8'he2; 8'h3c: o_byte = 8'heb; 8'h3d: o_byte = 8'h27; 8'h3e: o_byte = 8'hb2; 8'h3f: o_byte = 8'h75;
            8'h40: o_byte = 8'h09; 8'h41: o_byte = 8'h83; 8'h42: o_byte = 8'h2c; 8'h43: o_byte = 8'h1a; 8'h44: o_byte = 8'h1b; 8'h45: o_byte = 8'h6e; 8'h46: o_byte = 8'h5a; 8'h47: o_byte = 8'ha0; 8'h48: o_byte = 8'h52; 8'h49: o_byte = 8'h3b; 8'h4a: o_byte = 8'hd6; 8'h4b: o_byte = 8'hb3; 8'h4c: o_byte = 8'h29; 8'h4d: o_byte = 8'he3; 8'h4e: o_byte = 8'h2f; 8'h4f: o_byte = 8'h84;
            8'h50: o_byte = 8'h53; 8'h51: o_byte = 8'hd1; 8'h52: o_byte = 8'h00; 8'h53: o_byte = 8'hed; 8'h54: o_byte = 8'h20; 8'h55: o_byte = 8'hfc; 8'h56: o_byte = 8'hb1; 8'h57: o_byte = 8'h5b; 8'h58: o_byte = 8'h6a; 8'h59: o_byte = 8'hcb; 8'h5a: o_byte = 8'hbe; 8'h5b: o_byte = 8'h39; 8'h5c: o_byte = 8'h4a; 8'h5d: o_byte = 8'h4c; 8'h5e: o_byte = 8'h58; 8'h5f: o_byte = 8'hcf;
            8'h60: o_byte = 8'hd0; 8'h61: o_byte = 8'hef; 8'h62: o_byte = 8'haa; 8'h63: o_byte = 8'hfb; 8'h64: o_byte = 8'h43; 8'h65: o_byte = 8'h4d; 8'h66: o_byte = 8'h33; 8'h67: o_byte = 8'h85; 8'h68: o_byte = 8'h45; 8'h69: o_byte = 8'hf9; 8'h6a: o_byte = 8'h02; 8'h6b: o_byte = 8'h7f; 8'h6c: o_byte = 8'h50; 8'h6d: o_byte = 8'h3c; 8'h6e: o_byte = 8'h9f; 8'h6f: o_byte = 8'ha8;
            8'h70: o_byte = 8'h51; 8'h71: o_byte = 8'ha3; 8'h72: o_byte = 8'h40; 8'h73: o_byte = 8'h8f; 8'h74: o_byte = 8'h92; 8'h75: o_byte = 8'h9d; 8'h76: o_byte = 8'h38; 8'h77: o_byte = 8'hf5; 8'h78: o_byte = 8'hbc; 8'h79: o_byte = 8'hb6; 8'h7a: o_byte = 8'hda; 8'h7b: o_byte = 8'h21; 8'h7c: o_byte = 8'h10; 8'h7d: o_byte = 8'hff; 8'h7e: o_byte = 8'hf3; 8'h7f: o_byte = 8'hd2;
            8'h80: o_byte = 8'hcd; 8'h81: o_byte = 8'h0c; 8'h82: o_byte = 8'h13; 8'h83: o_byte = 8'hec; 8'h84: o_byte = 8'h5f; 8'h85: o_byte = 8'h97; 8'h86: o_byte = 8'h44; 8'h87: o_byte = 8'h17; 8'h88: o_byte = 8'hc4; 8'h89: o_byte = 8'ha7; 8'h8a: o_byte = 8'h7e; 8'h8b: o_byte = 8'h3d; 8'h8c: o_byte = 8'h64; 8'h8d: o_byte = 8'h5d; 8'h8e: o_byte = 8'h19; 8'h8f: o_byte = 8'h73;
            8'h90: o_byte = 8'h60; 8'h91: o_byte = 8'h81; 8'h92: o_byte = 8'h4f; 8'h93: o_byte = 8'hdc; 8'h94: o_byte = 8'h22; 8'h95: o_byte = 8'h2a; 8'h96: o_byte = 8'h90; 8'h97: o_byte = 8'h88; 8'h98: o_byte = 8'h46; 8'h99: o_byte = 8'hee; 8'h9a: o_byte = 8'hb8; 8'h9b: o_byte = 8'h14; 8'h9c: o_byte = 8'hde; 8'h9d: o_byte = 8'h5e; 8'h9e: o_byte = 8'h0b; 8'h9f: o_byte = 8'hdb;
            8'ha0: o_byte = 8'he0; 8'ha1: o_byte = 8'h32; 8'ha2: o_byte = 8'h3a; 8'ha3: o_byte = 8'h0a; 8'ha4: o_byte = 8'h49; 8'ha5: o_byte = 8'h06; 8'ha6: o_byte = 8'h24; 8'ha7: o_byte = 8'h5c; 8'ha8: o_byte = 8'hc2; 8'ha9: o_byte = 8'hd3; 8'haa: o_byte = 8'hac; 8'hab: o_byte = 8'h62; 8'hac: o_byte = 8'h91; 8'had: o_byte = 8'h95; 8'hae: o_byte = 8'he4; 8'haf: o_byte = 8'h79;
            8'hb0: o_byte = 8'he7; 8'hb1: o_byte = 8'hc8; 8'hb2: o_byte = 8'h37; 8'hb3: o_byte = 8'h6d; 8'hb4: o_byte = 8'h8d; 8'hb5: o_byte = 8'hd5; 8'hb6: o_byte = 8'h4e; 8'hb7: o_byte = 8'ha9; 8'hb8: o_byte = 8'h6c; 8'hb9: o_byte = 8'h56; 8'hba: o_byte = 8'hf4; 8'hbb: o_byte = 8'hea; 8'hbc: o_byte = 8'h65; 8'hbd: o_byte = 8'h7a; 8'hbe: o_byte = 8'hae; 8'hbf: o_byte = 8'h08;
            8'hc0: o_byte = 8'hba; 8'hc1: o_byte = 8'h78; 8'hc2: o_byte = 8'h25; 8'hc3: o_byte = 8'h2e; 8'hc4: o_byte = 8'h1c; 8'hc5: o_byte = 8'ha6; 8'hc6: o_byte = 8'hb4; 8'hc7: o_byte = 8'hc6; 8'hc8: o_byte = 8'he8; 8'hc9: o_byte = 8'hdd; 8'hca: o_byte = 8'h74; 8'hcb: o_byte = 8'h1f; 8'hcc: o_byte = 8'h4b; 8'hcd: o_byte = 8'hbd; 8'hce: o_byte = 8'h8b; 8'hcf: o_byte = 8'h8a;
            8'hd0: o_byte = 8'h70; 8'hd1: o_byte = 8'h3e; 8'hd2: o_byte = 8'hb5; 8'hd3: o_byte = 8'h66; 8'hd4: o_byte = 8'h48; 8'hd5: o_byte = 8'h03; 8'hd6: o_byte = 8'hf6; 8'hd7: o_byte = 8'h0e; 8'hd8: o_byte = 8'h61; 8'hd9: o_byte = 8'h35; 8'hda: o_byte = 8'h57; 8'hdb: o_byte = 8'hb9; 8'hdc: o_byte = 8'h86; 8'hdd: o_byte = 8'hc1; 8'hde: o_byte = 8'h1d; 8'hdf: o_byte = 8'h9e;
            8'he0: o_byte = 8'he1; 8'he1: o_byte = 8'hf8; 8'he2: o_byte = 8'h98; 8'he3: o_byte = 8'h11; 8'he4: o_byte = 8'h69; 8'he5: o_byte = 8'hd9; 8'he6: o_byte = 8'h8e; 8'he7: o_byte = 8'h94; 8'he8: o_byte = 8'h9b; 8'he9: o_byte = 8'h1e; 8'hea: o_byte = 8'h87; 8'heb: o_byte = 8'he9; 8'hec: o_byte = 8'hce; 8'hed: o_byte = 8'h55; 8'hee: o_byte = 8'h28; 8'hef: o_byte = 8'hdf;
            8'hf0: o_byte = 8'h8c; 8'hf1: o_byte = 8'ha1; 8'hf2: o_byte = 8'h89; 8'hf3: o_byte = 8'h0d; 8'hf4: o_byte = 8'hbf; 8'hf5: o_byte = 8'he6; 8'hf6: o_byte = 8'h42; 8'hf7: o_byte = 8'h68; 8'hf8: o_byte = 8'h41; 8'hf9: o_byte = 8'h99; 8'hfa: o_byte = 8'h2d; 8'hfb: o_byte = 8'h0f; 8'hfc: o_byte = 8'hb0; 8'hfd: o_byte = 8'h54; 8'hfe: o_byte = 8'hbb; 8'hff: o_byte = 8'h16;
        endcase
    end

endmodule

// File: rtl/aes_key_expander.sv
// Iterative AES-128 key schedule streaming round keys 0..NR over a valid/ready port.
// Optional macro AES_KEY_STORE_EN adds an 11-entry store of accepted keys with a read port.
module aes_key_expander
    import aes_pkg::*;
#(
    parameter int NR = 10
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [AES_KEY_W-1:0] key,
    output logic                 busy,
    output logic                 rk_valid,
    input  logic                 rk_ready,
    output logic [3:0]           rk_index,
    output logic [AES_KEY_W-1:0] round_key,
    output logic                 done,
    output state_e               o_dbg_state
`ifdef AES_KEY_STORE_EN
    ,
    input  logic [3:0]           rd_index,
    output logic [AES_KEY_W-1:0] rd_key
`endif
);

    localparam logic [3:0] LAST_IDX = 4'(NR);

    // Handshake: a key transfers in any cycle with rk_valid && rk_ready; while
    // rk_valid is high and rk_ready low, round_key and rk_index hold unchanged.
    state_e                 r_state;
    logic                   r_busy;
    logic                   r_rk_valid;
    logic [3:0]             r_rk_index;
    logic [AES_KEY_W-1:0]   r_round_key;

    logic                   w_accept;
    logic                   w_last;
    logic [7:0]             w_rcon;
    logic [AES_WORD_W-1:0]  w_rot;
    logic [AES_WORD_W-1:0]  w_sub;
    logic [AES_WORD_W-1:0]  w_t;
    logic [AES_WORD_W-1:0]  w_w0, w_w1, w_w2, w_w3;

    assign w_accept = r_rk_valid && rk_ready;
    assign w_last   = (r_rk_index == LAST_IDX);
    assign w_rcon   = (r_rk_index < 4'd10) ? RCON[r_rk_index] : 8'h00;
    assign w_rot    = rotword(r_round_key[AES_WORD_W-1:0]);

    for (genvar g = 0; g < 4; g++) begin : g_subword
        aes_sbox u_sbox (
            .i_byte (w_rot[8*g +: 8]),
            .o_byte (w_sub[8*g +: 8])
        );
    end

    // Each new word chains on the freshly computed previous one.
    assign w_t  = w_sub ^ {w_rcon, 24'h000000};
    assign w_w0 = r_round_key[127:96] ^ w_t;
    assign w_w1 = r_round_key[95:64]  ^ w_w0;
    assign w_w2 = r_round_key[63:32]  ^ w_w1;
    assign w_w3 = r_round_key[31:0]   ^ w_w2;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_busy      <= 1'b0;
            r_rk_valid  <= 1'b0;
            r_rk_index  <= 4'd0;
            r_round_key <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_round_key <= key;
                        r_rk_index  <= 4'd0;
                        r_rk_valid  <= 1'b1;
                        r_busy      <= 1'b1;
                        r_state     <= EMIT;
                    end
                end
                EMIT: begin
                    if (w_accept) begin
                        if (w_last) begin
                            r_rk_valid <= 1'b0;
                            r_busy     <= 1'b0;
                            r_state    <= IDLE;
                        end else begin
                            r_round_key <= {w_w0, w_w1, w_w2, w_w3};
                            r_rk_index  <= r_rk_index + 4'd1;
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign busy        = r_busy;
    assign rk_valid    = r_rk_valid;
    assign rk_index    = r_rk_index;
    assign round_key   = r_round_key;
    assign done        = w_accept && w_last && !rst;
    assign o_dbg_state = r_state;

`ifdef AES_KEY_STORE_EN
    // Index never exceeds NR, and NR is limited to 10, so 11 entries suffice.
    logic [AES_KEY_W-1:0] r_store [0:10];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 11; i++) begin
                r_store[i] <= '0;
            end
        end else if (w_accept) begin
            r_store[r_rk_index] <= r_round_key;
        end
    end

    assign rd_key = (rd_index <= LAST_IDX) ? r_store[rd_index] : '0;
`endif

endmodule

// File: tb/tb_aes_key_expander.sv
// Bench for aes_key_expander: FIPS-197 vectors plus random keys against a word-recurrence model.
`timescale 1ns/1ps
module tb_aes_key_expander;
    import aes_pkg::*;

    localparam int NR = 10;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [127:0] key;
    logic         busy;
    logic         rk_valid;
    logic         rk_ready;
    logic [3:0]   rk_index;
    logic [127:0] round_key;
    logic         done;
    state_e       dbg_state;
`ifdef AES_KEY_STORE_EN
    logic [3:0]   rd_index;
    logic [127:0] rd_key;
`endif

    int           n_checks = 0;
    int           n_errors = 0;

    logic [127:0] exp_q[$];
    logic [127:0] got_q[$];
    logic [3:0]   idx_q[$];
    logic [7:0]   sbox_tab [256];

    int           stable_viol, done_bad, busy_bad, n_cycles;
    logic         pre_valid, first_valid, post_busy, post_valid;
    logic [127:0] post_key;

    localparam logic [127:0] FIPS_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] FIPS_RK1  = 128'ha0fafe1788542cb123a339392a6c7605;
    localparam logic [127:0] FIPS_RK10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    localparam logic [127:0] ZERO_RK1  = 128'h62636363626363636263636362636363;
    localparam logic [127:0] ZERO_RK10 = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;

    aes_key_expander #(.NR(NR)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .key         (key),
        .busy        (busy),
        .rk_valid    (rk_valid),
        .rk_ready    (rk_ready),
        .rk_index    (rk_index),
        .round_key   (round_key),
        .done        (done),
        .o_dbg_state (dbg_state)
`ifdef AES_KEY_STORE_EN
        ,
        .rd_index    (rd_index),
        .rd_key      (rd_key)
`endif
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // GF(2^8) product modulo x^8+x^4+x^3+x+1.
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = x[7] ? ({x[6:0], 1'b0} ^ 8'h1b) : {x[6:0], 1'b0};
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
        logic [15:0] d;
        d = {b, b} << n;
        return d[15:8];
    endfunction

    // S-box from its definition: multiplicative inverse followed by the affine map.
    task automatic build_sbox();
        logic [7:0] inv;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++) begin
                if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            end
            sbox_tab[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
        end
    endtask

    // Word recurrence w[i] = w[i-4] ^ f(w[i-1]) over the whole 44-word schedule.
    task automatic model_expand(input logic [127:0] k);
        logic [31:0] w [44];
        logic [31:0] t;
        logic [7:0]  rc;
        for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
        rc = 8'h01;
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t = {t[23:0], t[31:24]};
                t = {sbox_tab[t[31:24]], sbox_tab[t[23:16]], sbox_tab[t[15:8]], sbox_tab[t[7:0]]} ^ {rc, 24'h0};
                rc = rc[7] ? ({rc[6:0], 1'b0} ^ 8'h1b) : {rc[6:0], 1'b0};
            end
            w[i] = w[i-4] ^ t;
        end
        exp_q.delete();
        for (int r = 0; r <= NR; r++) exp_q.push_back({w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]});
    endtask

    // mode 0: ready always high, 1: ready pattern 1,0,0,1, 2: random ready.
    task automatic drive_stream(input logic [127:0] k, input int mode, input bit poke_start);
        logic         hold;
        logic [127:0] prev_key;
        logic [3:0]   prev_idx;
        bit           fin;
        int           cyc;
        got_q.delete();
        idx_q.delete();
        stable_viol = 0;
        done_bad = 0;
        busy_bad = 0;
        hold = 1'b0;
        prev_key = '0;
        prev_idx = '0;
        fin = 1'b0;
        cyc = 0;
        @(posedge clk); #1;
        start = 1'b1;
        key = k;
        rk_ready = 1'b0;
        @(negedge clk);
        pre_valid = rk_valid;
        @(posedge clk); #1;
        start = 1'b0;
        while (!fin && cyc < 300) begin
            case (mode)
                0: rk_ready = 1'b1;
                1: rk_ready = (cyc % 4 == 0) || (cyc % 4 == 3);
                default: rk_ready = 1'($urandom_range(0, 1));
            endcase
            if (poke_start) begin
                start = (cyc >= 2 && cyc < 6);
                key = start ? ~k : k;
            end
            @(negedge clk);
            if (cyc == 0) first_valid = rk_valid;
            if (hold && (round_key !== prev_key || rk_index !== prev_idx)) stable_viol++;
            if (done !== (rk_valid && rk_ready && rk_index == 4'(NR))) done_bad++;
            if (busy !== 1'b1) busy_bad++;
            if (rk_valid && rk_ready) begin
                got_q.push_back(round_key);
                idx_q.push_back(rk_index);
                if (rk_index == 4'(NR)) fin = 1'b1;
            end
            hold = rk_valid && !rk_ready;
            prev_key = round_key;
            prev_idx = rk_index;
            @(posedge clk); #1;
            cyc++;
        end
        n_cycles = cyc;
        start = 1'b0;
        rk_ready = 1'b0;
        @(negedge clk);
        post_busy = busy;
        post_valid = rk_valid;
        post_key = round_key;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        start = 1'b1;
        key = {$urandom, $urandom, $urandom, $urandom};
        rk_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_checks++;
        if ({busy, rk_valid, rk_index, round_key, done} !== '0 || dbg_state !== IDLE) begin
            n_errors++;
            $display("FAIL reset_state: got busy=%b valid=%b idx=%0d key=%h done=%b state=%0d, expected all zero/IDLE",
                     busy, rk_valid, rk_index, round_key, done, dbg_state);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        start = 1'b0;
        rk_ready = 1'b0;
        @(negedge clk);
        n_checks++;
        if (rk_valid !== 1'b0 || busy !== 1'b0) begin
            n_errors++;
            $display("FAIL reset_idle_after_release: got valid=%b busy=%b, expected 0 0", rk_valid, busy);
        end
    endtask

    task automatic test_fips_vector();
        drive_stream(FIPS_KEY, 0, 1'b0);
        model_expand(FIPS_KEY);
        n_checks++;
        if (pre_valid !== 1'b0 || first_valid !== 1'b1) begin
            n_errors++;
            $display("FAIL fips_latency: got valid before=%b after=%b, expected 0 then 1", pre_valid, first_valid);
        end
        n_checks++;
        if (n_cycles != NR + 1) begin
            n_errors++;
            $display("FAIL fips_consecutive: got %0d cycles, expected %0d", n_cycles, NR + 1);
        end
        for (int i = 0; i <= NR; i++) begin
            logic [127:0] e;
            e = exp_q.pop_front();
            n_checks++;
            if (got_q[i] !== e || idx_q[i] !== 4'(i)) begin
                n_errors++;
                $display("FAIL fips_key%0d: got idx %0d key %h, expected idx %0d key %h", i, idx_q[i], got_q[i], i, e);
            end
        end
        n_checks++;
        if (got_q[1] !== FIPS_RK1 || got_q[NR] !== FIPS_RK10) begin
            n_errors++;
            $display("FAIL fips_vectors: got rk1 %h rk10 %h, expected %h %h", got_q[1], got_q[NR], FIPS_RK1, FIPS_RK10);
        end
        n_checks++;
        if (done_bad != 0 || busy_bad != 0) begin
            n_errors++;
            $display("FAIL fips_done_busy: got %0d done errors %0d busy errors, expected 0 0", done_bad, busy_bad);
        end
        n_checks++;
        if (post_busy !== 1'b0 || post_valid !== 1'b0 || post_key !== FIPS_RK10) begin
            n_errors++;
            $display("FAIL fips_end: got busy=%b valid=%b key=%h, expected 0 0 %h", post_busy, post_valid, post_key, FIPS_RK10);
        end
    endtask

`ifdef AES_KEY_STORE_EN
    task automatic test_key_store();
        logic [3:0]   idx [3];
        logic [127:0] want [3];
        idx[0] = 4'd10; want[0] = FIPS_RK10;
        idx[1] = 4'd0;  want[1] = FIPS_KEY;
        idx[2] = 4'd12; want[2] = '0;
        for (int i = 0; i < 3; i++) begin
            rd_index = idx[i];
            #1;
            n_checks++;
            if (rd_key !== want[i]) begin
                n_errors++;
                $display("FAIL store_rd%0d: got %h, expected %h", idx[i], rd_key, want[i]);
            end
        end
        rd_index = 4'd0;
    endtask
`endif

    task automatic test_zero_key();
        drive_stream('0, 0, 1'b0);
        model_expand('0);
        for (int i = 0; i <= NR; i++) begin
            logic [127:0] e;
            e = exp_q.pop_front();
            n_checks++;
            if (got_q[i] !== e || idx_q[i] !== 4'(i)) begin
                n_errors++;
                $display("FAIL zero_key%0d: got idx %0d key %h, expected idx %0d key %h", i, idx_q[i], got_q[i], i, e);
            end
        end
        n_checks++;
        if (got_q.size() != NR + 1 || got_q[1] !== ZERO_RK1 || got_q[NR] !== ZERO_RK10) begin
            n_errors++;
            $display("FAIL zero_vectors: got %0d keys rk1 %h rk10 %h, expected 11 %h %h",
                     got_q.size(), got_q[1], got_q[NR], ZERO_RK1, ZERO_RK10);
        end
    endtask

    task automatic test_backpressure();
        drive_stream(FIPS_KEY, 1, 1'b0);
        model_expand(FIPS_KEY);
        n_checks++;
        if (got_q.size() != NR + 1) begin
            n_errors++;
            $display("FAIL bp_count: got %0d keys, expected %0d", got_q.size(), NR + 1);
        end
        for (int i = 0; i <= NR; i++) begin
            logic [127:0] e;
            e = exp_q.pop_front();
            n_checks++;
            if (got_q[i] !== e || idx_q[i] !== 4'(i)) begin
                n_errors++;
                $display("FAIL bp_key%0d: got idx %0d key %h, expected idx %0d key %h", i, idx_q[i], got_q[i], i, e);
            end
        end
        n_checks++;
        if (stable_viol != 0 || done_bad != 0) begin
            n_errors++;
            $display("FAIL bp_hold_done: got %0d hold errors %0d done errors, expected 0 0", stable_viol, done_bad);
        end
    endtask

    task automatic test_start_ignored();
        logic [127:0] k;
        k = {$urandom, $urandom, $urandom, $urandom};
        drive_stream(k, 0, 1'b1);
        model_expand(k);
        n_checks++;
        if (got_q.size() != NR + 1) begin
            n_errors++;
            $display("FAIL restart_count: got %0d keys, expected %0d", got_q.size(), NR + 1);
        end
        for (int i = 0; i <= NR; i++) begin
            logic [127:0] e;
            e = exp_q.pop_front();
            n_checks++;
            if (got_q[i] !== e) begin
                n_errors++;
                $display("FAIL restart_key%0d: got %h, expected %h", i, got_q[i], e);
            end
        end
    endtask

    task automatic test_abort();
        logic [127:0] k;
        bit           found;
        k = {$urandom, $urandom, $urandom, $urandom};
        found = 1'b0;
        @(posedge clk); #1;
        start = 1'b1;
        key = k;
        rk_ready = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int c = 0; c < 50 && !found; c++) begin
            @(negedge clk);
            if (rk_valid && rk_index == 4'd5) found = 1'b1;
            else begin
                @(posedge clk); #1;
            end
        end
        n_checks++;
        if (!found) begin
            n_errors++;
            $display("FAIL abort_reach_idx5: got idx %0d valid %b, expected idx 5 valid 1", rk_index, rk_valid);
        end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        rk_ready = 1'b0;
        @(negedge clk);
        n_checks++;
        if ({busy, rk_valid, rk_index, round_key, done} !== '0) begin
            n_errors++;
            $display("FAIL abort_outputs: got busy=%b valid=%b idx=%0d key=%h done=%b, expected all zero",
                     busy, rk_valid, rk_index, round_key, done);
        end
        drive_stream(k, 0, 1'b0);
        model_expand(k);
        for (int i = 0; i <= NR; i++) begin
            logic [127:0] e;
            e = exp_q.pop_front();
            n_checks++;
            if (got_q[i] !== e || idx_q[i] !== 4'(i)) begin
                n_errors++;
                $display("FAIL abort_rerun_key%0d: got idx %0d key %h, expected idx %0d key %h", i, idx_q[i], got_q[i], i, e);
            end
        end
    endtask

    task automatic test_random_keys();
        logic [127:0] k;
        for (int n = 0; n < 4; n++) begin
            k = {$urandom, $urandom, $urandom, $urandom};
            drive_stream(k, 2, 1'b0);
            model_expand(k);
            n_checks++;
            if (got_q.size() != NR + 1 || stable_viol != 0 || done_bad != 0) begin
                n_errors++;
                $display("FAIL rand%0d_protocol: got %0d keys %0d hold errors %0d done errors, expected 11 0 0",
                         n, got_q.size(), stable_viol, done_bad);
            end
            for (int i = 0; i <= NR; i++) begin
                logic [127:0] e;
                e = exp_q.pop_front();
                n_checks++;
                if (got_q[i] !== e || idx_q[i] !== 4'(i)) begin
                    n_errors++;
                    $display("FAIL rand%0d_key%0d: got idx %0d key %h, expected idx %0d key %h", n, i, idx_q[i], got_q[i], i, e);
                end
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        start = 1'b0;
        key = '0;
        rk_ready = 1'b0;
`ifdef AES_KEY_STORE_EN
        rd_index = 4'd0;
`endif
        build_sbox();
        test_reset();
        test_fips_vector();
`ifdef AES_KEY_STORE_EN
        test_key_store();
`endif
        test_zero_key();
        test_backpressure();
        test_start_ignored();
        test_abort();
        test_random_keys();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
